// File: rtl/xor_fold_stream_pkg.sv
// rtl/xor_fold_stream_pkg.sv - shared mode encoding and parameter defaults for the XOR fold stream
package xor_fold_stream_pkg;

    localparam logic MODE_BEAT  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

    localparam int WIDTH_DEFAULT = 8;
    localparam int LANES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/xor_fold_stream_if.sv
// rtl/xor_fold_stream_if.sv - beat input and result output handshake bundle
interface xor_fold_stream_if
    import xor_fold_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LANES = LANES_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic [LANES*WIDTH-1:0] I_DATA;
    logic                   I_VALID;
    logic                   I_LAST;
    logic                   I_MODE;
    logic                   I_READY;
    logic [WIDTH-1:0]       O_DATA;
    logic [CNT_W-1:0]       O_COUNT;
    logic                   O_OVF;
    logic                   O_VALID;
    logic                   O_READY;

    modport slave (
        input  I_DATA, I_VALID, I_LAST, I_MODE, O_READY,
        output I_READY, O_DATA, O_COUNT, O_OVF, O_VALID
    );

    modport master (
        output I_DATA, I_VALID, I_LAST, I_MODE, O_READY,
        input  I_READY, O_DATA, O_COUNT, O_OVF, O_VALID
    );

endinterface

// File: rtl/xor_fold_stream_reduce.sv
// rtl/xor_fold_stream_reduce.sv - combinational LANES x WIDTH XOR reduction
module xor_lane_reduce #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]       o_xor
);

    always_comb begin
        o_xor = '0;
        for (int k = 0; k < LANES; k++) begin
            o_xor = o_xor ^ i_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/xor_fold_stream.sv
// rtl/xor_fold_stream.sv - pipelined XOR fold with per-beat or per-frame accumulation
module xor_fold_stream
    import xor_fold_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LANES = LANES_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    xor_fold_stream_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_fold;
    logic             w_mode_in;
    logic             w_a_complete;
    logic             w_out_free;
    logic             w_a_advance;
    logic             w_i_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_ovf_n;

    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_data;
    logic             r_a_last;
    logic             r_a_mode;
    logic             r_a_open;

    logic             r_in_frame;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             r_o_valid;
    logic [WIDTH-1:0] r_o_data;
    logic [CNT_W-1:0] r_o_count;
    logic             r_o_ovf;

    xor_lane_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .i_data (bus.I_DATA),
        .o_xor  (w_fold)
    );

    // Stage A tracks its own open-frame flag: the next beat is accepted in the
    // same edge the previous one moves to stage B, before r_in_frame is updated.
    assign w_mode_in    = r_a_open ? MODE_FRAME : bus.I_MODE;
    assign w_a_complete = r_a_valid & ((r_a_mode == MODE_BEAT) | r_a_last);
    assign w_out_free   = !r_o_valid | bus.O_READY;
    assign w_a_advance  = r_a_valid & (!w_a_complete | w_out_free);
    assign w_i_ready    = ASYNCRESETN & (!r_a_valid | w_a_advance);
    assign w_accept     = bus.I_VALID & w_i_ready;

    assign w_acc_n = (r_in_frame ? r_acc : {WIDTH{1'b0}}) ^ r_a_data;
    assign w_cnt_n = r_in_frame ? ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1) : CNT_W'(1);
    assign w_ovf_n = r_in_frame & (r_ovf | (r_cnt == CNT_MAX));

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_last  <= 1'b0;
            r_a_mode  <= MODE_BEAT;
            r_a_open  <= 1'b0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_data  <= w_fold;
            r_a_last  <= bus.I_LAST;
            r_a_mode  <= w_mode_in;
            r_a_open  <= (w_mode_in == MODE_FRAME) & !bus.I_LAST;
        end else if (w_a_advance) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_in_frame <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_a_advance) begin
            if (w_a_complete) begin
                r_in_frame <= 1'b0;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_in_frame <= 1'b1;
                r_acc      <= w_acc_n;
                r_cnt      <= w_cnt_n;
                r_ovf      <= w_ovf_n;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_count <= '0;
            r_o_ovf   <= 1'b0;
        end else if (w_a_advance & w_a_complete) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_acc_n;
            r_o_count <= w_cnt_n;
            r_o_ovf   <= w_ovf_n;
        end else if (bus.O_READY) begin
            r_o_valid <= 1'b0;
        end
    end

    assign bus.I_READY = w_i_ready;
    assign bus.O_VALID = r_o_valid;
    assign bus.O_DATA  = r_o_data;
    assign bus.O_COUNT = r_o_count;
    assign bus.O_OVF   = r_o_ovf;

endmodule
